// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared defaults and helpers for the writeback-stage regfile write arbiter.
//   - Default parameter values (requester count, data width, address width)
//   - Requester index assignments (ALU, load return, mul/div)
//   - rr_wrap: modular index helper used by the round-robin search
// -----------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

    localparam int NUM_REQ_DEFAULT        = 3;
    localparam int DATA_WIDTH_DEFAULT     = 32;
    localparam int REG_ADDR_WIDTH_DEFAULT = 5;

    // Fixed requester slots on the write port.
    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

    // (base + offset) mod n, valid for base < n and offset <= n, so a
    // single conditional subtraction is enough.
    function automatic int rr_wrap(input int base, input int offset, input int n);
        int sum;
        sum = base + offset;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter over NUM_REQ requests. The search starts one past the
// last granted index; the lowest index after the pointer wins. The pointer
// moves to the granted index whenever a grant is issued (the consumer always
// accepts, so every grant is a transfer).
// Ports:
//   i_Clk          clock
//   i_Reset_n      asynchronous active-low reset; also forces grants to 0
//   i_Req          per-requester request
//   o_Grant        one-hot grant (combinational)
//   o_Grant_Valid  any grant issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    input  logic [NUM_REQ-1:0] i_Req,
    output logic [NUM_REQ-1:0] o_Grant,
    output logic               o_Grant_Valid
);

    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   idx_s;
    logic               found_s;
    logic [NUM_REQ-1:0] grant_s;
    int                 cand_s;

    // Search for the first active request after the pointer.
    always_comb begin
        idx_s   = {IDX_W{1'b0}};
        found_s = 1'b0;
        cand_s  = 0;
        grant_s = {NUM_REQ{1'b0}};
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = rr_wrap(int'(ptr_r), i, NUM_REQ);
            if (!found_s && i_Req[IDX_W'(cand_s)]) begin
                found_s = 1'b1;
                idx_s   = IDX_W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
        // No grants are visible while the block is held in reset.
        found_s = found_s & i_Reset_n;
        if (found_s) begin
            grant_s[idx_s] = 1'b1;
        end else begin
            grant_s = {NUM_REQ{1'b0}};
        end
    end

    // Pointer register; reset value makes index 0 the first one searched.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ptr_r <= IDX_W'(NUM_REQ - 1);
        end else if (found_s) begin
            ptr_r <= idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign o_Grant       = grant_s;
    assign o_Grant_Valid = found_s;

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the regfile's single write port among NUM_REQ result producers using
// round-robin arbitration, with a registered stage driving the write port.
// Writes to register 0 are accepted but produce no write enable.
// Optional feature macro: REGWR_ARB_SCOREBOARD_EN
//   defined   -> per-register pending-write scoreboard with busy lookups
//   undefined -> no scoreboard state, busy outputs tied low
// Ports:
//   i_Clk, i_Reset_n           clock, async active-low reset
//   i_Req_Valid/Addr/Data      flattened requester inputs (k at [k*W +: W])
//   o_Req_Ready                one-hot grant, transfer on valid & ready
//   o_Write_Enable/Addr/Data   regfile write port (registered)
//   i_Reserve_Valid/Addr       issue-stage destination claim
//   i_RS_Addr, i_RT_Addr       scoreboard lookup addresses
//   o_RS_Busy, o_RT_Busy       lookup register has a pending write
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEFAULT,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
    input  logic                              i_Clk,
    input  logic                              i_Reset_n,
    input  logic [NUM_REQ-1:0]                i_Req_Valid,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] i_Req_Addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     i_Req_Data,
    output logic [NUM_REQ-1:0]                o_Req_Ready,
    output logic                              o_Write_Enable,
    output logic [REG_ADDR_WIDTH-1:0]         o_Write_Addr,
    output logic [DATA_WIDTH-1:0]             o_Write_Data,
    input  logic                              i_Reserve_Valid,
    input  logic [REG_ADDR_WIDTH-1:0]         i_Reserve_Addr,
    input  logic [REG_ADDR_WIDTH-1:0]         i_RS_Addr,
    input  logic [REG_ADDR_WIDTH-1:0]         i_RT_Addr,
    output logic                              o_RS_Busy,
    output logic                              o_RT_Busy
);

    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    logic [NUM_REQ-1:0]        grant_s;
    logic                      xfer_s;
    logic [REG_ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0]     sel_data_s;
    logic                      we_r;
    logic [REG_ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0]     data_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_Clk         (i_Clk),
        .i_Reset_n     (i_Reset_n),
        .i_Req         (i_Req_Valid),
        .o_Grant       (grant_s),
        .o_Grant_Valid (xfer_s)
    );

    // One-hot AND-OR mux of the granted requester's address and data.
    always_comb begin
        sel_addr_s = {REG_ADDR_WIDTH{1'b0}};
        sel_data_s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_s[k]) begin
                sel_addr_s = sel_addr_s | i_Req_Addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                sel_data_s = sel_data_s | i_Req_Data[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_addr_s = sel_addr_s;
                sel_data_s = sel_data_s;
            end
        end
    end

    // Write-port output stage; addr/data hold between transfers, r0 writes
    // are loaded but never enabled.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            we_r   <= 1'b0;
            addr_r <= {REG_ADDR_WIDTH{1'b0}};
            data_r <= {DATA_WIDTH{1'b0}};
        end else if (xfer_s) begin
            we_r   <= (sel_addr_s != {REG_ADDR_WIDTH{1'b0}});
            addr_r <= sel_addr_s;
            data_r <= sel_data_s;
        end else begin
            we_r   <= 1'b0;
            addr_r <= addr_r;
            data_r <= data_r;
        end
    end

    assign o_Req_Ready    = grant_s;
    assign o_Write_Enable = we_r;
    assign o_Write_Addr   = addr_r;
    assign o_Write_Data   = data_r;

`ifdef REGWR_ARB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] sb_r;
    logic [NUM_REGS-1:0] sb_next_s;

    // Clear on the regfile write, then set on reserve so a same-edge
    // reserve of the same register keeps it busy. Bit 0 is never set.
    always_comb begin
        sb_next_s = sb_r;
        if (we_r) begin
            sb_next_s[addr_r] = 1'b0;
        end else begin
            sb_next_s = sb_next_s;
        end
        if (i_Reserve_Valid && (i_Reserve_Addr != {REG_ADDR_WIDTH{1'b0}})) begin
            sb_next_s[i_Reserve_Addr] = 1'b1;
        end else begin
            sb_next_s = sb_next_s;
        end
        sb_next_s[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sb_r <= {NUM_REGS{1'b0}};
        end else begin
            sb_r <= sb_next_s;
        end
    end

    assign o_RS_Busy = sb_r[i_RS_Addr];
    assign o_RT_Busy = sb_r[i_RT_Addr];
`else
    logic unused_sb_inputs_s;
    assign unused_sb_inputs_s = ^{i_Reserve_Valid, i_Reserve_Addr, i_RS_Addr, i_RT_Addr};
    assign o_RS_Busy = 1'b0;
    assign o_RT_Busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Directed bench for regfile_write_arbiter (NUM_REQ=3, 32-bit data, 5-bit
// addresses). A table of per-cycle vectors covers arbitration and the output
// stage; hand-written sequences cover the scoreboard and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            res_valid;
    logic [AW-1:0]   res_addr;
    logic [AW-1:0]   rs_addr;
    logic [AW-1:0]   rt_addr;
    logic            rs_busy;
    logic            rt_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW)
    ) dut (
        .i_Clk           (clk),
        .i_Reset_n       (rst_n),
        .i_Req_Valid     (req_valid),
        .i_Req_Addr      (req_addr),
        .i_Req_Data      (req_data),
        .o_Req_Ready     (req_ready),
        .o_Write_Enable  (wr_en),
        .o_Write_Addr    (wr_addr),
        .o_Write_Data    (wr_data),
        .i_Reserve_Valid (res_valid),
        .i_Reserve_Addr  (res_addr),
        .i_RS_Addr       (rs_addr),
        .i_RT_Addr       (rt_addr),
        .o_RS_Busy       (rs_busy),
        .o_RT_Busy       (rt_busy)
    );

    typedef struct {
        logic [NR-1:0]    valid;
        logic [NR*AW-1:0] addr;
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    exp_ready;
        logic             exp_we;
        logic [AW-1:0]    exp_wa;
        logic [DW-1:0]    exp_wd;
    } vec_t;

    vec_t vecs [0:14];

    function automatic vec_t mk(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                                input logic [NR*DW-1:0] d, input logic [NR-1:0] r,
                                input logic we, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd);
        vec_t t;
        t.valid = v; t.addr = a; t.data = d;
        t.exp_ready = r; t.exp_we = we; t.exp_wa = wa; t.exp_wd = wd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next cycle and apply inputs 1 time unit after the edge;
    // returns 1 time unit later so combinational outputs have settled.
    task automatic drive(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                         input logic [NR*DW-1:0] d, input logic rv,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rsa,
                         input logic [AW-1:0] rta);
        @(posedge clk);
        #1;
        req_valid = v; req_addr = a; req_data = d;
        res_valid = rv; res_addr = ra; rs_addr = rsa; rt_addr = rta;
        #1;
    endtask

    logic [NR*AW-1:0] a_all;
    logic [NR*DW-1:0] d_all;
    logic [NR*AW-1:0] a_zero;
    logic [NR*DW-1:0] d_zero;

    initial begin
        a_all  = {5'd12, 5'd11, 5'd10};
        d_all  = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        a_zero = {NR*AW{1'b0}};
        d_zero = {NR*DW{1'b0}};

        // Hand-computed cycle table: inputs of cycle i and the outputs seen in
        // cycle i (write port reflects the transfer of cycle i-1).
        vecs[0]  = mk(3'b000, a_zero, d_zero, 3'b000, 1'b0, 5'd0,  32'h0);
        vecs[1]  = mk(3'b111, a_all,  d_all,  3'b001, 1'b0, 5'd0,  32'h0);
        vecs[2]  = mk(3'b111, a_all,  d_all,  3'b010, 1'b1, 5'd10, 32'hA0);
        vecs[3]  = mk(3'b111, a_all,  d_all,  3'b100, 1'b1, 5'd11, 32'hA1);
        vecs[4]  = mk(3'b111, a_all,  d_all,  3'b001, 1'b1, 5'd12, 32'hA2);
        vecs[5]  = mk(3'b111, a_all,  d_all,  3'b010, 1'b1, 5'd10, 32'hA0);
        vecs[6]  = mk(3'b111, a_all,  d_all,  3'b100, 1'b1, 5'd11, 32'hA1);
        vecs[7]  = mk(3'b000, a_zero, d_zero, 3'b000, 1'b1, 5'd12, 32'hA2);
        vecs[8]  = mk(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                      3'b010, 1'b0, 5'd12, 32'hA2);
        vecs[9]  = mk(3'b000, a_zero, d_zero, 3'b000, 1'b1, 5'd5,  32'hDEADBEEF);
        vecs[10] = mk(3'b000, a_zero, d_zero, 3'b000, 1'b0, 5'd5,  32'hDEADBEEF);
        vecs[11] = mk(3'b100, {5'd0, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0},
                      3'b100, 1'b0, 5'd5,  32'hDEADBEEF);
        vecs[12] = mk(3'b101, {5'd4, 5'd0, 5'd3}, {32'h44, 32'h0, 32'h33},
                      3'b001, 1'b0, 5'd0,  32'h77);
        vecs[13] = mk(3'b100, {5'd4, 5'd0, 5'd3}, {32'h44, 32'h0, 32'h33},
                      3'b100, 1'b1, 5'd3,  32'h33);
        vecs[14] = mk(3'b000, a_zero, d_zero, 3'b000, 1'b1, 5'd4,  32'h44);

        rst_n = 1'b0;
        req_valid = 3'b000; req_addr = a_zero; req_data = d_zero;
        res_valid = 1'b0; res_addr = 5'd0; rs_addr = 5'd7; rt_addr = 5'd0;

        // Reset state, including ready suppressed while in reset.
        repeat (2) @(posedge clk);
        #1;
        req_valid = 3'b111;
        #1;
        chk("rst_we",    {31'd0, wr_en},   32'd0);
        chk("rst_waddr", {27'd0, wr_addr}, 32'd0);
        chk("rst_wdata", wr_data,          32'd0);
        chk("rst_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_rs_busy", {31'd0, rs_busy}, 32'd0);
        chk("rst_rt_busy", {31'd0, rt_busy}, 32'd0);
        @(negedge clk);
        req_valid = 3'b000;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].valid, vecs[i].addr, vecs[i].data, 1'b0, 5'd0, 5'd7, 5'd0);
            chk($sformatf("v%0d_ready", i), {29'd0, req_ready}, {29'd0, vecs[i].exp_ready});
            chk($sformatf("v%0d_we", i),    {31'd0, wr_en},     {31'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_waddr", i), {27'd0, wr_addr},   {27'd0, vecs[i].exp_wa});
            chk($sformatf("v%0d_wdata", i), wr_data,            vecs[i].exp_wd);
        end

`ifdef REGWR_ARB_SCOREBOARD_EN
        // Reserve r7, write it back, then reserve again on the clearing edge.
        drive(3'b000, a_zero, d_zero, 1'b1, 5'd7, 5'd7, 5'd7);
        chk("sb_pre_busy", {31'd0, rs_busy}, 32'd0);
        drive(3'b000, a_zero, d_zero, 1'b0, 5'd0, 5'd7, 5'd3);
        chk("sb_set_rs", {31'd0, rs_busy}, 32'd1);
        chk("sb_set_rt_other", {31'd0, rt_busy}, 32'd0);
        drive(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h70}, 1'b0, 5'd0, 5'd7, 5'd7);
        chk("sb_wr_ready", {29'd0, req_ready}, 32'd1);
        chk("sb_wr_busy_n", {31'd0, rs_busy}, 32'd1);
        drive(3'b000, a_zero, d_zero, 1'b0, 5'd0, 5'd7, 5'd7);
        chk("sb_wr_we", {31'd0, wr_en}, 32'd1);
        chk("sb_wr_busy_n1", {31'd0, rt_busy}, 32'd1);
        drive(3'b000, a_zero, d_zero, 1'b0, 5'd0, 5'd7, 5'd7);
        chk("sb_clr_busy_n2", {31'd0, rs_busy}, 32'd0);
        drive(3'b000, a_zero, d_zero, 1'b1, 5'd7, 5'd7, 5'd7);
        drive(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h71, 32'h0}, 1'b0, 5'd0, 5'd7, 5'd7);
        chk("sb_re_ready", {29'd0, req_ready}, 32'd2);
        chk("sb_re_busy", {31'd0, rs_busy}, 32'd1);
        drive(3'b000, a_zero, d_zero, 1'b1, 5'd7, 5'd7, 5'd7);
        chk("sb_same_we", {31'd0, wr_en}, 32'd1);
        chk("sb_same_wd", wr_data, 32'h71);
        drive(3'b000, a_zero, d_zero, 1'b1, 5'd0, 5'd7, 5'd0);
        chk("sb_same_edge_busy", {31'd0, rs_busy}, 32'd1);
        chk("sb_r0_busy", {31'd0, rt_busy}, 32'd0);
        drive(3'b000, a_zero, d_zero, 1'b0, 5'd0, 5'd7, 5'd0);
        chk("sb_hold_busy", {31'd0, rs_busy}, 32'd1);
        chk("sb_r0_never", {31'd0, rt_busy}, 32'd0);
`else
        // Without the scoreboard, reservations have no visible effect.
        drive(3'b000, a_zero, d_zero, 1'b1, 5'd7, 5'd7, 5'd7);
        drive(3'b000, a_zero, d_zero, 1'b0, 5'd0, 5'd7, 5'd7);
        chk("nosb_rs_busy", {31'd0, rs_busy}, 32'd0);
        chk("nosb_rt_busy", {31'd0, rt_busy}, 32'd0);
`endif

        // Reset while a req2 write is pending on the output stage.
        drive(3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 1'b1, 5'd9, 5'd9, 5'd0);
        chk("rr_req2_ready", {29'd0, req_ready}, 32'd4);
        drive(3'b111, {5'd9, 5'd2, 5'd1}, {32'h99, 32'h22, 32'h11}, 1'b0, 5'd0, 5'd9, 5'd0);
        chk("rr_pending_we", {31'd0, wr_en}, 32'd1);
        chk("rr_pending_wa", {27'd0, wr_addr}, 32'd9);
`ifdef REGWR_ARB_SCOREBOARD_EN
        chk("rr_pending_busy", {31'd0, rs_busy}, 32'd1);
`endif
        rst_n = 1'b0;
        #1;
        chk("rr_we_dropped", {31'd0, wr_en}, 32'd0);
        chk("rr_wa_cleared", {27'd0, wr_addr}, 32'd0);
        chk("rr_wd_cleared", wr_data, 32'd0);
        chk("rr_ready_in_reset", {29'd0, req_ready}, 32'd0);
        chk("rr_busy_cleared", {31'd0, rs_busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rr_req0_first", {29'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("rr_post_we", {31'd0, wr_en}, 32'd1);
        chk("rr_post_wa", {27'd0, wr_addr}, 32'd1);
        chk("rr_post_wd", wr_data, 32'h11);
        req_valid = 3'b000;
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
